// File: rtl/timer_counter_pkg.sv
// Shared constants for the timer peripheral: FSM states, register offsets,
// CTRL bit positions, mode encodings and the byte-merge write helper.
package timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Processor-side data-bus view of one timer instance plus its interrupt line.
interface timer_counter_if;
  logic [3:2]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, byteen, wdata, input rdata, irq);
  modport slave  (input addr, we, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT registers, a four-state
// counting FSM, and a maskable interrupt flag.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | COUNT <= PRESET
// CNT   | decrementing COUNT toward terminal count
// INT   | terminal count reached; one-shot stops, auto-reload reloads
module timer_counter
  import timer_pkg::*;
(
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);

  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic [1:0]  state_q,    state_d;
  logic        irq_flag_q, irq_flag_d;

  logic        en;
  logic [1:0]  mode;
  logic [31:0] wr_old;
  logic [31:0] wr_val;

  assign en   = ctrl_q[CTRL_EN];
  assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // Only one register is written per access, so one merge serves both.
  assign wr_old = (bus.addr == OFF_CTRL) ? {28'd0, ctrl_q} : preset_q;
  assign wr_val = byte_merge(wr_old, bus.wdata, bus.byteen);

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      default: begin
        if (mode == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
    endcase

    // CPU writes are applied last so they override the FSM on the same edge.
    if (bus.we) begin
      case (bus.addr)
        OFF_CTRL: begin
          ctrl_d     = wr_val[3:0];
          irq_flag_d = 1'b0;
        end
        OFF_PRESET: preset_d = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (bus.addr)
      OFF_CTRL:   bus.rdata = {28'd0, ctrl_q};
      OFF_PRESET: bus.rdata = preset_q;
      OFF_COUNT:  bus.rdata = count_q;
      default:    bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed vector table, hand-written
// multi-cycle sequences, and random bus traffic against a behavioural model.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  chk_addr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference model.
  typedef enum {PH_IDLE, PH_LOAD, PH_COUNT, PH_IRQ} phase_e;
  phase_e      m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;

  function automatic vec_t mk(input logic we, input logic [1:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic [1:0] ca, input logic [31:0] er,
                              input logic ei);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wd = wd;
    v.chk_addr = ca; v.exp_rdata = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    bus.we = we; bus.addr = addr; bus.byteen = be; bus.wdata = wd;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    drive(1'b1, addr, 4'hF, wd);
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    bus.addr = addr;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    chk(name, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 2'd0, 4'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    case (addr)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic we, input logic [1:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
    phase_e      n_phase = m_phase;
    logic [3:0]  n_ctrl  = m_ctrl;
    logic [31:0] n_pre   = m_preset;
    logic [31:0] n_cnt   = m_count;
    logic        n_flag  = m_flag;
    if (m_phase == PH_IDLE && m_ctrl[0]) n_phase = PH_LOAD;
    if (m_phase == PH_LOAD) begin
      n_cnt = m_preset;
      n_phase = PH_COUNT;
    end
    if (m_phase == PH_COUNT) begin
      if (!m_ctrl[0]) n_phase = PH_IDLE;
      else if (m_count >= 2) n_cnt = m_count - 1;
      else begin
        n_cnt = 0; n_flag = 1'b1; n_phase = PH_IRQ;
      end
    end
    if (m_phase == PH_IRQ) begin
      if (m_ctrl[2:1] == 2'd1) begin
        n_flag = 1'b0; n_phase = PH_LOAD;
      end else begin
        n_ctrl[0] = 1'b0; n_phase = PH_IDLE;
      end
    end
    if (we && addr == 2'd0) begin
      if (be[0]) n_ctrl = wd[3:0];
      n_flag = 1'b0;
    end
    if (we && addr == 2'd1) begin
      for (int b = 0; b < 4; b++) if (be[b]) n_pre[8*b +: 8] = wd[8*b +: 8];
    end
    m_phase = n_phase; m_ctrl = n_ctrl; m_preset = n_pre; m_count = n_cnt; m_flag = n_flag;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, 4'd0, 32'd0);
    do_reset();

    // Directed table: each row is one cycle of bus activity then a read/irq check.
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 3, 32'h0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 32'd3, 1, 32'd3, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h9, 0, 32'h9, 0));    // edge 0: enable
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd0, 0));    // edge 1: LOAD
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd3, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd2, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd0, 1));    // edge 5: INT
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 0, 32'h8, 1));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 0, 32'h8, 1));
    tbl.push_back(mk(1, 0, 4'hF, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 32'h11223344, 1, 32'h11223344, 0));
    tbl.push_back(mk(1, 1, 4'h2, 32'hAABBCCDD, 1, 32'h1122CC44, 0));
    tbl.push_back(mk(1, 2, 4'hF, 32'hFFFFFFFF, 2, 32'h0, 0));
    tbl.push_back(mk(1, 3, 4'hF, 32'hFFFFFFFF, 3, 32'h0, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'hFFFFFFF8, 0, 32'h8, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 32'd1, 1, 32'd1, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h1, 0, 32'h1, 0));    // IM=0 one-shot
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 2, 32'd0, 0));    // flag set, masked
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h8, 0, 32'h8, 0));    // IM on clears flag
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 0, 32'h8, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (i < 4) begin
        drive(1'b0, tbl[i].addr, 4'h0, 32'h0);
      end else begin
        drive(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd);
        tick();
        bus.we = 1'b0;
      end
      rd_chk($sformatf("tbl%0d_rdata", i), tbl[i].chk_addr, tbl[i].exp_rdata);
      irq_chk($sformatf("tbl%0d_irq", i), tbl[i].exp_irq);
    end

    // Auto-reload, PRESET=2: pulse every 4 cycles, COUNT reloads to 2.
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 14; e++) begin
      int p;
      logic [31:0] ec;
      p  = (e - 2) % 4;
      ec = (e == 1) ? 32'd0 : (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
      tick();
      rd_chk($sformatf("reload_count_e%0d", e), 2'd2, ec);
      irq_chk($sformatf("reload_irq_e%0d", e), (e >= 2) && (p == 2));
    end

    // Stop mid-count at COUNT=5, then re-enable; PRESET write mid-count.
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int e = 1; e <= 6; e++) tick();
    rd_chk("stop_pre", 2'd2, 32'd6);
    wr(2'd0, 32'h0);
    rd_chk("stop_e7", 2'd2, 32'd5);
    for (int e = 8; e <= 10; e++) begin
      tick();
      rd_chk($sformatf("stop_hold_e%0d", e), 2'd2, 32'd5);
      irq_chk($sformatf("stop_irq_e%0d", e), 1'b0);
    end
    wr(2'd0, 32'h1);
    rd_chk("restart_e0", 2'd2, 32'd5);
    tick();
    rd_chk("restart_load", 2'd2, 32'd5);
    tick();
    rd_chk("restart_preset", 2'd2, 32'd10);
    wr(2'd1, 32'd7);
    rd_chk("preset_write_no_effect", 2'd2, 32'd9);
    tick();
    rd_chk("count_continues", 2'd2, 32'd8);

    // Reset mid-count.
    wr(2'd0, 32'h9);
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) rd_chk($sformatf("midreset_off%0d", a), a[1:0], 32'd0);
    irq_chk("midreset_irq", 1'b0);
    reset = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic        we;
      logic [1:0]  addr;
      logic [3:0]  be;
      logic [31:0] wd;
      we   = ($urandom_range(0, 5) == 0);
      addr = 2'($urandom_range(0, 3));
      be   = 4'($urandom_range(1, 15));
      wd   = $urandom();
      if (addr == 2'd1 && $urandom_range(0, 3) != 0) wd = $urandom_range(0, 12);
      drive(we, addr, be, wd);
      #1;
      chk($sformatf("rand%0d_rdata", n), bus.rdata, model_read(addr));
      irq_chk($sformatf("rand%0d_irq", n), m_flag & m_ctrl[3]);
      model_edge(we, addr, be, wd);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
